sd_spi_responder: RTL and testbench

//  Card side of the SD SPI-mode command link: SPI mode-0 slave that receives 6-byte command

---
 rtl/sd_spi_responder.sv | 215 +++++++++++++++++++++
 tb/tb_sd_spi_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_responder.sv
// SD SPI-mode card-side command responder (SPI mode 0 slave).
// Receives 6-byte command frames on mosi, decodes them and answers with
// NCR_BYTES idle bytes followed by an R1 status byte on miso.
// Optional CRC7 checking of the command frame is enabled by defining the
// macro SD_RESP_CRC_CHECK_EN; without it the CRC field is ignored.
module sd_spi_responder #(
    parameter int NCR_BYTES   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        busy,
    output logic        in_idle
);

    typedef enum logic [1:0] {ST_HUNT, ST_CMD, ST_NCR, ST_RESP} state_t;

    localparam logic [2:0] LP_LAST_BYTE = 3'(NCR_BYTES - 1);

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic        r_sclk_d;
    logic        w_sclk, w_cs_n, w_mosi, w_rise, w_fall;
    state_t      r_state, w_state_nxt;
    logic [46:0] r_frame;
    logic [47:0] w_frame_nxt;
    logic [5:0]  r_cnt;
    logic [2:0]  r_bit, r_byte;
    logic        r_ncr_done;
    logic [7:0]  r_r1, r_r1_sh;
    logic        r_miso, r_cmd_valid, r_in_idle;
    logic [5:0]  r_cmd_index;
    logic [31:0] r_cmd_arg;
    logic        w_eval, w_supported, w_illegal, w_crc_err, w_accept, w_idle_new;
    logic [7:0]  w_r1;

    // Synchronise the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // Delayed synced sclk for rise/fall detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sclk_d <= 1'b0;
        else        r_sclk_d <= w_sclk;
    end

    assign w_rise      = w_sclk & ~r_sclk_d;
    assign w_fall      = ~w_sclk & r_sclk_d;
    assign w_frame_nxt = {r_frame, w_mosi};

`ifdef SD_RESP_CRC_CHECK_EN
    // CRC7, polynomial x^7 + x^3 + 1, zero initial value, MSB first
    function automatic logic [6:0] crc7(input logic [39:0] msg);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ msg[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    assign w_crc_err = (crc7(w_frame_nxt[47:8]) != w_frame_nxt[7:1]);
`else
    logic w_unused_crc;
    assign w_crc_err    = 1'b0;
    assign w_unused_crc = ^{w_frame_nxt[47], w_frame_nxt[7:1]};
`endif

    // Decode the frame as it completes (the 48th bit is the live mosi sample)
    always_comb begin
        w_supported = 1'b0;
        case (w_frame_nxt[45:40])
            6'd0, 6'd1, 6'd16, 6'd17, 6'd24: w_supported = 1'b1;
            default:                         w_supported = 1'b0;
        endcase
        w_illegal  = ~w_frame_nxt[46] | ~w_frame_nxt[0] | ~w_supported;
        w_accept   = ~w_illegal & ~w_crc_err;
        w_idle_new = r_in_idle;
        if (w_accept && w_frame_nxt[45:40] == 6'd0) w_idle_new = 1'b1;
        if (w_accept && w_frame_nxt[45:40] == 6'd1) w_idle_new = 1'b0;
        w_r1 = {4'b0000, w_crc_err, w_illegal, 1'b0, w_idle_new};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_HUNT;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; cs_n high overrides everything and returns to HUNT
    always_comb begin
        w_state_nxt = r_state;
        w_eval      = 1'b0;
        if (w_cs_n) begin
            w_state_nxt = ST_HUNT;
        end else begin
            case (r_state)
                ST_HUNT: if (w_rise && !w_mosi) w_state_nxt = ST_CMD;
                ST_CMD: if (w_rise && r_cnt == 6'd47) begin
                    w_eval      = 1'b1;
                    w_state_nxt = ST_NCR;
                end
                ST_NCR:  if (w_fall && r_ncr_done) w_state_nxt = ST_RESP;
                ST_RESP: if (w_rise && r_bit == 3'd7) w_state_nxt = ST_HUNT;
                default: w_state_nxt = ST_HUNT;
            endcase
        end
    end

    // Frame shifter and response byte datapath (no reset needed)
    always_ff @(posedge clk) begin
        if (w_rise && (r_state == ST_HUNT || r_state == ST_CMD))
            r_frame <= w_frame_nxt[46:0];
        if (w_eval)
            r_r1 <= w_r1;
        if (r_state == ST_NCR && w_fall && r_ncr_done)
            r_r1_sh <= {r_r1[6:0], 1'b0};
        else if (r_state == ST_RESP && w_fall)
            r_r1_sh <= {r_r1_sh[6:0], 1'b0};
    end

    // Counters, miso driver and decoded command outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_bit       <= '0;
            r_byte      <= '0;
            r_ncr_done  <= 1'b0;
            r_miso      <= 1'b1;
            r_cmd_valid <= 1'b0;
            r_cmd_index <= '0;
            r_cmd_arg   <= '0;
            r_in_idle   <= 1'b1;
        end else begin
            r_cmd_valid <= 1'b0;
            if (w_cs_n) begin
                r_miso     <= 1'b1;
                r_cnt      <= '0;
                r_bit      <= '0;
                r_byte     <= '0;
                r_ncr_done <= 1'b0;
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        if (w_fall) r_miso <= 1'b1;
                        if (w_rise && !w_mosi) r_cnt <= 6'd1;
                    end
                    ST_CMD: if (w_rise) begin
                        r_cnt <= r_cnt + 6'd1;
                        if (w_eval) begin
                            r_bit       <= '0;
                            r_byte      <= '0;
                            r_ncr_done  <= 1'b0;
                            r_cmd_valid <= w_accept;
                            r_in_idle   <= w_idle_new;
                            if (w_accept) begin
                                r_cmd_index <= w_frame_nxt[45:40];
                                r_cmd_arg   <= w_frame_nxt[39:8];
                            end
                        end
                    end
                    ST_NCR: begin
                        if (w_rise && !r_ncr_done) begin
                            if (r_bit == 3'd7) begin
                                r_bit <= '0;
                                if (r_byte == LP_LAST_BYTE) r_ncr_done <= 1'b1;
                                else                        r_byte <= r_byte + 3'd1;
                            end else begin
                                r_bit <= r_bit + 3'd1;
                            end
                        end
                        if (w_fall && r_ncr_done) begin
                            r_miso <= r_r1[7];
                            r_bit  <= '0;
                        end
                    end
                    ST_RESP: begin
                        if (w_rise) r_bit  <= r_bit + 3'd1;
                        if (w_fall) r_miso <= r_r1_sh[7];
                    end
                    default: r_miso <= 1'b1;
                endcase
            end
        end
    end

    assign miso      = r_miso;
    assign cmd_valid = r_cmd_valid;
    assign cmd_index = r_cmd_index;
    assign cmd_arg   = r_cmd_arg;
    assign busy      = (r_state != ST_HUNT);
    assign in_idle   = r_in_idle;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Self-checking bench for sd_spi_responder: directed SD command vectors plus
// randomized frames checked against a frame-level behavioural card model.
module tb_sd_spi_responder;

    localparam int NCR  = 2;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n, sclk, cs_n, mosi;
    logic        miso, cmd_valid, busy, in_idle;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          pulses = 0;
    logic [5:0]  cap_idx;
    logic [31:0] cap_arg;

    // card model state
    logic        m_idle;
    logic [5:0]  m_idx;
    logic [31:0] m_arg;

    sd_spi_responder #(.NCR_BYTES(NCR), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .cmd_valid(cmd_valid), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .busy(busy), .in_idle(in_idle)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            pulses  = pulses + 1;
            cap_idx = cmd_index;
            cap_arg = cmd_arg;
        end
    end

    // CRC7 as polynomial long division of msg * x^7 by x^7 + x^3 + 1
    function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
        logic [46:0] v;
        v = {msg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        return v[6:0];
    endfunction

    function automatic logic [47:0] mk(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        return {m, ref_crc7(m), 1'b1};
    endfunction

    // Card behaviour for one complete frame
    task automatic model_frame(input logic [47:0] f, output logic [7:0] r1, output bit acc);
        logic [5:0] idx;
        logic       ill, crc_err;
        idx = f[45:40];
        ill = !f[46] || !f[0] || !(idx inside {6'd0, 6'd1, 6'd16, 6'd17, 6'd24});
`ifdef SD_RESP_CRC_CHECK_EN
        crc_err = (ref_crc7(f[47:8]) != f[7:1]);
`else
        crc_err = 1'b0;
`endif
        acc = !ill && !crc_err;
        if (acc) begin
            m_idx = idx;
            m_arg = f[39:8];
            if (idx == 6'd0) m_idle = 1'b1;
            if (idx == 6'd1) m_idle = 1'b0;
        end
        r1 = {4'b0000, crc_err, ill, 1'b0, m_idle};
    endtask

    // One SPI mode-0 byte: drive mosi while sclk low, sample miso at the rise
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #40;
            sclk  = 1'b1;
            rx[i] = miso;
            #40;
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input string nm, input logic [47:0] f, output logic [7:0] r1_obs);
        logic [7:0] rx, exp_r1, all;
        bit         acc;
        int         p0;
        model_frame(f, exp_r1, acc);
        p0  = pulses;
        all = 8'hFF;
        for (int b = 5; b >= 0; b--) begin
            xfer(f[b*8 +: 8], rx);
            all &= rx;
        end
        n_cmp++; if (all !== 8'hFF) begin n_bad++; $display("FAIL %s miso_cmd: got %h expected ff", nm, all); end
        for (int n = 0; n < NCR; n++) begin
            xfer(8'hFF, rx);
            n_cmp++; if (rx !== 8'hFF) begin n_bad++; $display("FAIL %s ncr%0d: got %h expected ff", nm, n, rx); end
        end
        xfer(8'hFF, rx);
        r1_obs = rx;
        n_cmp++; if (rx !== exp_r1) begin n_bad++; $display("FAIL %s r1: got %h expected %h", nm, rx, exp_r1); end
        xfer(8'hFF, rx);
        n_cmp++; if (rx !== 8'hFF) begin n_bad++; $display("FAIL %s trail: got %h expected ff", nm, rx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy: got %b expected 0", nm, busy); end
        n_cmp++; if (pulses - p0 != int'(acc)) begin n_bad++; $display("FAIL %s pulses: got %0d expected %0d", nm, pulses - p0, int'(acc)); end
        n_cmp++; if (cmd_index !== m_idx) begin n_bad++; $display("FAIL %s index: got %0d expected %0d", nm, cmd_index, m_idx); end
        n_cmp++; if (cmd_arg !== m_arg) begin n_bad++; $display("FAIL %s arg: got %h expected %h", nm, cmd_arg, m_arg); end
        n_cmp++; if (in_idle !== m_idle) begin n_bad++; $display("FAIL %s in_idle: got %b expected %b", nm, in_idle, m_idle); end
        if (acc) begin
            n_cmp++; if (cap_idx !== m_idx || cap_arg !== m_arg) begin n_bad++; $display("FAIL %s pulse_data: got %0d/%h expected %0d/%h", nm, cap_idx, cap_arg, m_idx, m_arg); end
        end
    endtask

    task automatic reset_model();
        m_idle = 1'b1;
        m_idx  = '0;
        m_arg  = '0;
    endtask

    task automatic test_reset();
        logic [7:0] rx;
        logic [7:0] r1;
        bit         acc;
        logic [47:0] f;
        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b1;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (miso !== 1'b1) begin n_bad++; $display("FAIL rst miso: got %b expected 1", miso); end
        n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL rst cmd_valid: got %b expected 0", cmd_valid); end
        n_cmp++; if (cmd_index !== 6'd0 || cmd_arg !== 32'd0) begin n_bad++; $display("FAIL rst cmd: got %0d/%h expected 0/0", cmd_index, cmd_arg); end
        n_cmp++; if (busy !== 1'b0 || in_idle !== 1'b1) begin n_bad++; $display("FAIL rst flags: got busy=%b idle=%b expected 0/1", busy, in_idle); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        // CMD1 then reset while the R1 byte is being shifted out
        f = 48'h41_0000_0000_F9;
        model_frame(f, r1, acc);
        for (int b = 5; b >= 0; b--) xfer(f[b*8 +: 8], rx);
        for (int n = 0; n < NCR; n++) xfer(8'hFF, rx);
        for (int i = 0; i < 3; i++) begin
            #40; sclk = 1'b1; #40; sclk = 1'b0;
        end
        #20;
        n_cmp++; if (busy !== 1'b1 || in_idle !== 1'b0) begin n_bad++; $display("FAIL resp_state: got busy=%b idle=%b expected 1/0", busy, in_idle); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (miso !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL midresp_rst: got miso=%b busy=%b expected 1/0", miso, busy); end
        n_cmp++; if (in_idle !== 1'b1 || cmd_valid !== 1'b0 || cmd_index !== 6'd0) begin n_bad++; $display("FAIL midresp_rst2: got idle=%b v=%b idx=%0d expected 1/0/0", in_idle, cmd_valid, cmd_index); end
        reset_model();
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_cmd0_cmd1();
        logic [7:0] r1;
        run_frame("cmd0", 48'h40_0000_0000_95, r1);
        n_cmp++; if (r1 !== 8'h01) begin n_bad++; $display("FAIL cmd0_r1: got %h expected 01", r1); end
        run_frame("cmd1", 48'h41_0000_0000_F9, r1);
        n_cmp++; if (r1 !== 8'h00 || cmd_index !== 6'd1) begin n_bad++; $display("FAIL cmd1_r1: got %h/%0d expected 00/1", r1, cmd_index); end
    endtask

    task automatic test_bad_crc();
        logic [7:0] r1;
        run_frame("cmd17", 48'h51_0000_0200_01, r1);
`ifdef SD_RESP_CRC_CHECK_EN
        n_cmp++; if (r1 !== 8'h08) begin n_bad++; $display("FAIL cmd17_r1: got %h expected 08", r1); end
`else
        n_cmp++; if (r1 !== 8'h00 || cmd_arg !== 32'h200) begin n_bad++; $display("FAIL cmd17_r1: got %h/%h expected 00/00000200", r1, cmd_arg); end
`endif
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        logic [7:0] r1;
        int         p0;
        p0 = pulses;
        xfer(8'h40, rx); xfer(8'h00, rx); xfer(8'h00, rx);
        cs_n = 1'b1;
        #40;
        n_cmp++; if (busy !== 1'b0 || miso !== 1'b1) begin n_bad++; $display("FAIL abort: got busy=%b miso=%b expected 0/1", busy, miso); end
        n_cmp++; if (pulses != p0 || in_idle !== m_idle) begin n_bad++; $display("FAIL abort_side: got pulses=%0d idle=%b expected %0d/%b", pulses, in_idle, p0, m_idle); end
        #40;
        cs_n = 1'b0;
        #80;
        xfer(8'hFF, rx);
        n_cmp++; if (rx !== 8'hFF) begin n_bad++; $display("FAIL abort_nor1: got %h expected ff", rx); end
        run_frame("abort_cmd0", 48'h40_0000_0000_95, r1);
        n_cmp++; if (r1 !== 8'h01) begin n_bad++; $display("FAIL abort_cmd0_r1: got %h expected 01", r1); end
    endtask

    task automatic test_illegal();
        logic [7:0] r1;
        run_frame("cmd5", mk(6'd5, 32'd0), r1);
        n_cmp++; if (r1 !== 8'h05 || cmd_index !== 6'd0) begin n_bad++; $display("FAIL cmd5_r1: got %h/%0d expected 05/0", r1, cmd_index); end
    endtask

    task automatic test_random();
        logic [7:0]  r1;
        logic [47:0] f;
        logic [5:0]  idx;
        logic [5:0]  sup [5];
        sup[0] = 6'd0; sup[1] = 6'd1; sup[2] = 6'd16; sup[3] = 6'd17; sup[4] = 6'd24;
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 2))
                0:       idx = sup[$urandom_range(0, 4)];
                1:       idx = 6'($urandom_range(0, 63));
                default: idx = 6'($urandom_range(0, 1));
            endcase
            f = mk(idx, $urandom);
            if ($urandom_range(0, 7) == 0) f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
            if ($urandom_range(0, 9) == 0) f[46] = 1'b0;
            if ($urandom_range(0, 9) == 0) f[0] = 1'b0;
            run_frame("rand", f, r1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r1;
        run_frame("b2b_cmd24", mk(6'd24, 32'hDEAD_BEEF), r1);
        run_frame("b2b_cmd16", mk(6'd16, 32'h0000_0200), r1);
        run_frame("b2b_cmd0", mk(6'd0, 32'h0), r1);
        run_frame("b2b_cmd63", mk(6'd63, 32'h1234_5678), r1);
        run_frame("b2b_cmd1", mk(6'd1, 32'h0), r1);
    endtask

    initial begin
        test_reset();
        test_cmd0_cmd1();
        test_bad_crc();
        test_abort();
        test_illegal();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
